audio_codec_seq: RTL and testbench
==================================

Name: audio_codec_seq

Overview:
Power-up and rate-change sequencer for the ADC/PLL/DAC audio path on the Mojo board. It drives the PLL rate-select pins and the ADC format/mode pins, then waits for the PLL to settle. It then qualifies the ADC LRCK and unmutes the DAC only once samples are stable. The block sits inside mojo_top on the 50 MHz clk domain and monitors the ADC LRCK for loss of clock.

Parameters:
PLL_SETTLE_CYC, 500000, clk cycles to wait after PLL pins change (10 ms at 50 MHz).
ADC_SETTLE_FRAMES, 1024, LRCK rising edges to discard before unmute.
LRCK_TIMEOUT_CYC, 4096, max clk cycles between LRCK rising edges before fault.
PLL_CSEL, 1'b0, constant value driven on o_pll_csel.
ADC_FMT, 1'b0, constant value driven on o_adc_fmt.
ADC_MD, 2'b00, constant {md2,md1} driven on ADC mode pins.

Ports:
clk  in  1  50 MHz system clock.
rst  in  1  reset. Synchronous, active-high.
i_adc_lrck  in  1  ADC LRCK, asynchronous to clk.
i_rate_sel  in  2  requested rate: 00=48k, 01=44.1k, 10=32k, 11=96k.
i_rate_req  in  1  one-cycle pulse; applies i_rate_sel.
i_mute_req  in  1  level; forces DAC mute while high.
o_pll_csel  out  1  PLL clock select.
o_pll_fs1  out  1  PLL FS1.
o_pll_fs2  out  1  PLL FS2.
o_pll_sr  out  1  PLL standard/double rate.
o_adc_fmt  out  1  ADC format pin.
o_adc_md1  out  1  ADC mode pin 1.
o_adc_md2  out  1  ADC mode pin 2.
o_dac_nmute  out  1  DAC unmute, active-high.
o_ready  out  1  high in RUN.
o_err  out  1  sticky LRCK-loss fault.
o_state  out  3  current state encoding, for debug.

Behaviour:
- Reset: values below appear on the first clk edge with rst=1.
  - Outputs: o_dac_nmute=0, o_ready=0, o_err=0; rate register=00; {fs2,fs1,sr}=000.
  - Constant pins: csel/fmt/md pins are driven from their parameters at all times.
  - State: CFG.
- Rate encoding {fs2,fs1,sr}: 00 gives 000; 01 gives 010; 10 gives 100; 11 gives 001. The PLL pins are registered from the rate register.
- LRCK path: 2-flop synchronizer plus an edge flop. A rising-edge pulse is produced 3 clk cycles after the pin edge.
- States (o_state): CFG=0, PLL_WAIT=1, ADC_SYNC=2, ADC_SETTLE=3, RUN=4, FAULT=5.
  - CFG: load the rate register and update the PLL pins. Clear the counters. Go to PLL_WAIT next cycle.
  - PLL_WAIT: count PLL_SETTLE_CYC cycles, then go to ADC_SYNC. LRCK is ignored in this state.
  - ADC_SYNC: wait for an LRCK edge. On the edge, go to ADC_SETTLE with frame count=0. If no edge arrives within LRCK_TIMEOUT_CYC cycles, go to FAULT.
  - ADC_SETTLE: count LRCK edges. On the ADC_SETTLE_FRAMES-th edge, go to RUN. A gap of LRCK_TIMEOUT_CYC cycles goes to FAULT.
  - RUN: monitor the LRCK gap; a timeout goes to FAULT.
  - FAULT: exit only on i_rate_req or rst.
- Timeout counter: cleared on every LRCK edge and on state entry. The timeout fires when the count reaches LRCK_TIMEOUT_CYC-1 with no edge in that cycle.
- Outputs (registered, valid in the same cycle as the state register):
  - o_ready = (state==RUN).
  - o_dac_nmute = (state==RUN) && !i_mute_req, with 1 cycle latency from i_mute_req.
  - o_err set on entry to FAULT; cleared only on entry to CFG or by rst.
- i_rate_req handling:
  - In RUN or ADC_SETTLE: ignored if i_rate_sel equals the rate register. Otherwise go to CFG.
  - In PLL_WAIT, ADC_SYNC or FAULT: always go to CFG, restarting the settle time.
  - In CFG: the new value overwrites, and CFG is re-entered.
  - o_dac_nmute drops on the cycle after the request.
- Simultaneous events: rst beats everything. i_rate_req beats an LRCK timeout in the same cycle. A timeout beats an LRCK edge in the same cycle; this cannot occur, since an edge clears the counter.
- Counter widths are sized by $clog2 of the parameters. No wrap-around is allowed: counters saturate and are cleared on state change.

Test Plan:
Common bench settings: PLL_SETTLE_CYC=100, ADC_SETTLE_FRAMES=4, LRCK_TIMEOUT_CYC=2000, LRCK period 1042 clk.
1. Power-up: rst high for 10 cycles, LRCK running -> pins {fs2,fs1,sr}=000; nmute=0 throughout PLL_WAIT (100 cycles); ready=1 and nmute=1 on the cycle after the 4th synchronized LRCK edge following PLL_WAIT.
2. LRCK held low after reset -> state=5 and o_err=1 exactly 2000 cycles after entering ADC_SYNC; nmute stays 0; i_rate_req=00 clears err and restarts from CFG.
3. In RUN, stop LRCK -> nmute=0, ready=0, err=1 at 2000 cycles after the last synchronized edge.
4. In RUN, pulse i_rate_req with sel=11 -> nmute=0 next cycle; pins become 001; full resequence to RUN. Then pulse with sel=11 again -> no state change, nmute stays 1.
5. In RUN, i_mute_req high for 5 cycles -> nmute low for exactly 5 cycles, delayed by 1 cycle; ready stays 1.
6. rst pulsed for 1 cycle mid-ADC_SETTLE (after 2 edges) -> all outputs return to reset values next cycle; state=CFG; 4 new edges are required before RUN.

Source files
------------

// File: rtl/audio_codec_seq.sv
// Power-up / rate-change sequencer for the ADC -> PLL -> DAC audio path.
// Programs the PLL rate pins, waits for lock, qualifies ADC LRCK, then unmutes the DAC.
module audio_codec_seq #(
   parameter int         PLL_SETTLE_CYC    = 500000,
   parameter int         ADC_SETTLE_FRAMES = 1024,
   parameter int         LRCK_TIMEOUT_CYC  = 4096,
   parameter logic       PLL_CSEL          = 1'b0,
   parameter logic       ADC_FMT           = 1'b0,
   parameter logic [1:0] ADC_MD            = 2'b00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_adc_lrck,
   input  logic [1:0] i_rate_sel,
   input  logic       i_rate_req,
   input  logic       i_mute_req,
   output logic       o_pll_csel,
   output logic       o_pll_fs1,
   output logic       o_pll_fs2,
   output logic       o_pll_sr,
   output logic       o_adc_fmt,
   output logic       o_adc_md1,
   output logic       o_adc_md2,
   output logic       o_dac_nmute,
   output logic       o_ready,
   output logic       o_err,
   output logic [2:0] o_state
);

   localparam int PW = $clog2(PLL_SETTLE_CYC + 1);
   localparam int TW = $clog2(LRCK_TIMEOUT_CYC + 1);
   localparam int FW = $clog2(ADC_SETTLE_FRAMES + 1);
   // The ADC_SYNC edge is the first settle frame, so ADC_SETTLE counts the remaining ones.
   localparam int FRM_LAST_I = (ADC_SETTLE_FRAMES > 1) ? ADC_SETTLE_FRAMES - 2 : 0;
   localparam logic [PW-1:0] PLL_LAST = PW'(PLL_SETTLE_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(LRCK_TIMEOUT_CYC - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(FRM_LAST_I);

   typedef enum logic [2:0] {
      CFG        = 3'd0,
      PLL_WAIT   = 3'd1,
      ADC_SYNC   = 3'd2,
      ADC_SETTLE = 3'd3,
      RUN        = 3'd4,
      FAULT      = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    rate_q, rate_d;
   logic [2:0]    pins_q, pins_d;
   logic [PW-1:0] pll_cnt_q, pll_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [FW-1:0] frm_cnt_q, frm_cnt_d;
   logic          lrck_s1_q, lrck_s2_q, lrck_s3_q;
   logic          ready_q, ready_d;
   logic          nmute_q, nmute_d;
   logic          err_q, err_d;
   logic          lrck_edge, tmo_fire, rate_new, entering;

   // {fs2,fs1,sr} for each requested sample rate.
   function automatic logic [2:0] rate_to_pins(input logic [1:0] rate);
      case (rate)
         2'b00:   return 3'b000;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

   assign lrck_edge = lrck_s2_q & ~lrck_s3_q;
   assign tmo_fire  = (tmo_cnt_q == TMO_LAST) && !lrck_edge;
   assign rate_new  = i_rate_req && (i_rate_sel != rate_q);

   always_comb begin
      state_d = state_q;
      rate_d  = rate_q;
      pins_d  = pins_q;
      case (state_q)
         CFG: begin
            pins_d  = rate_to_pins(rate_q);
            state_d = PLL_WAIT;
            if (i_rate_req) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end
         end
         PLL_WAIT: begin
            if (i_rate_req) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end else if (pll_cnt_q == PLL_LAST) begin
               state_d = ADC_SYNC;
            end
         end
         ADC_SYNC: begin
            if (i_rate_req) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end else if (tmo_fire) begin
               state_d = FAULT;
            end else if (lrck_edge) begin
               state_d = (ADC_SETTLE_FRAMES > 1) ? ADC_SETTLE : RUN;
            end
         end
         ADC_SETTLE: begin
            if (rate_new) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end else if (tmo_fire) begin
               state_d = FAULT;
            end else if (lrck_edge && (frm_cnt_q == FRM_LAST)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (rate_new) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end else if (tmo_fire) begin
               state_d = FAULT;
            end
         end
         FAULT: begin
            if (i_rate_req) begin
               rate_d  = i_rate_sel;
               state_d = CFG;
            end
         end
         default: state_d = CFG;
      endcase
   end

   // All counters restart on state entry (CFG always counts as an entry) and saturate.
   always_comb begin
      entering  = (state_d != state_q) || (state_q == CFG);
      pll_cnt_d = pll_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      frm_cnt_d = frm_cnt_q;
      if (entering) begin
         pll_cnt_d = '0;
         tmo_cnt_d = '0;
         frm_cnt_d = '0;
      end else begin
         if (pll_cnt_q != PLL_LAST) pll_cnt_d = pll_cnt_q + 1'b1;
         if (lrck_edge)                   tmo_cnt_d = '0;
         else if (tmo_cnt_q != TMO_LAST)  tmo_cnt_d = tmo_cnt_q + 1'b1;
         if (lrck_edge && (frm_cnt_q != FRM_LAST)) frm_cnt_d = frm_cnt_q + 1'b1;
      end
   end

   always_comb begin
      ready_d = (state_d == RUN);
      nmute_d = (state_d == RUN) && !i_mute_req;
      err_d   = err_q;
      if ((state_d == FAULT) && (state_q != FAULT)) err_d = 1'b1;
      if (state_d == CFG)                           err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CFG;
         rate_q    <= 2'b00;
         pins_q    <= 3'b000;
         pll_cnt_q <= '0;
         tmo_cnt_q <= '0;
         frm_cnt_q <= '0;
         lrck_s1_q <= 1'b0;
         lrck_s2_q <= 1'b0;
         lrck_s3_q <= 1'b0;
         ready_q   <= 1'b0;
         nmute_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rate_q    <= rate_d;
         pins_q    <= pins_d;
         pll_cnt_q <= pll_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         frm_cnt_q <= frm_cnt_d;
         lrck_s1_q <= i_adc_lrck;
         lrck_s2_q <= lrck_s1_q;
         lrck_s3_q <= lrck_s2_q;
         ready_q   <= ready_d;
         nmute_q   <= nmute_d;
         err_q     <= err_d;
      end
   end

   assign o_pll_csel  = PLL_CSEL;
   assign o_adc_fmt   = ADC_FMT;
   assign o_adc_md1   = ADC_MD[0];
   assign o_adc_md2   = ADC_MD[1];
   assign o_pll_fs2   = pins_q[2];
   assign o_pll_fs1   = pins_q[1];
   assign o_pll_sr    = pins_q[0];
   assign o_dac_nmute = nmute_q;
   assign o_ready     = ready_q;
   assign o_err       = err_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_audio_codec_seq.sv
// Directed bench for audio_codec_seq: expected output snapshots are queued when
// stimulus is applied and compared when the sequencer reaches the predicted point.
module tb_audio_codec_seq;

   localparam int PLL  = 100;
   localparam int FRM  = 4;
   localparam int TMO  = 2000;
   localparam int HALF = 521;

   logic       clk = 1'b0;
   logic       rst, lrck, req, mute;
   logic [1:0] sel;
   logic       csel, fs1, fs2, sr, fmt, md1, md2, nmute, ready, err;
   logic [2:0] state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rises[$];
   bit lrck_en;
   bit nm_seen;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       rdy;
      logic       nm;
      logic       er;
      logic [2:0] pins;
   } exp_t;
   exp_t sbq[$];

   audio_codec_seq #(
      .PLL_SETTLE_CYC(PLL), .ADC_SETTLE_FRAMES(FRM), .LRCK_TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .i_adc_lrck(lrck), .i_rate_sel(sel), .i_rate_req(req),
      .i_mute_req(mute), .o_pll_csel(csel), .o_pll_fs1(fs1), .o_pll_fs2(fs2),
      .o_pll_sr(sr), .o_adc_fmt(fmt), .o_adc_md1(md1), .o_adc_md2(md2),
      .o_dac_nmute(nmute), .o_ready(ready), .o_err(err), .o_state(state)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // LRCK source: period 2*HALF clk; logs the cycle of each rising pin edge.
   initial begin
      int ph;
      ph   = 0;
      lrck = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!lrck_en) begin
            ph   = 0;
            lrck = 1'b0;
         end else begin
            ph++;
            if (ph == HALF) begin
               ph   = 0;
               lrck = ~lrck;
               if (lrck) rises.push_back(cyc);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (nmute !== 1'b0) nm_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic push_exp(input string tag, input logic [2:0] st, input logic rdy,
                           input logic nm, input logic er, input logic [2:0] pins);
      exp_t e;
      e.tag = tag; e.st = st; e.rdy = rdy; e.nm = nm; e.er = er; e.pins = pins;
      sbq.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, ".state"}, 32'(state), 32'(e.st));
      chk({e.tag, ".ready"}, 32'(ready), 32'(e.rdy));
      chk({e.tag, ".nmute"}, 32'(nmute), 32'(e.nm));
      chk({e.tag, ".err"},   32'(err),   32'(e.er));
      chk({e.tag, ".pins"},  32'({fs2, fs1, sr}), 32'(e.pins));
   endtask

   // Polls at negedges until o_state == st; at = cycle found or -1 on timeout.
   task automatic wait_state(input logic [2:0] st, input int budget, input string tag,
                             output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state === st) begin
            at = cyc;
            break;
         end
      end
      chk({tag, ".reached"}, 32'(at >= 0), 32'd1);
   endtask

   // Cycle at which the n-th synchronised LRCK edge (seen by logic after cycle s) takes effect.
   function automatic int edge_cycle(input int s, input int n);
      int k;
      k = 0;
      foreach (rises[i]) begin
         if (rises[i] + 3 > s) begin
            k++;
            if (k == n) return rises[i] + 3;
         end
      end
      return -1;
   endfunction

   task automatic pulse_req(input logic [1:0] v);
      @(posedge clk); #1;
      sel = v;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   initial begin
      int s, r, f, t_pw, e1, e2;
      logic [9:0] low_mask, rdy_mask;
      rst = 1'b1; sel = 2'b00; req = 1'b0; mute = 1'b0; lrck_en = 1'b1;

      // Power-up with LRCK running
      @(negedge clk);
      push_exp("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      check_out();
      chk("const_pins", 32'({csel, fmt, md2, md1}), 32'd0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      wait_state(3'd1, 5, "pll_entry", t_pw);
      chk("pll_entry_cycle", 32'(t_pw), 32'd11);
      nm_seen = 1'b0;
      wait_state(3'd2, 300, "sync_entry", s);
      chk("pll_wait_len", 32'(s - t_pw), 32'(PLL));
      chk("nmute_in_pll_wait", 32'(nm_seen), 32'd0);
      wait_state(3'd4, 6000, "run1", r);
      chk("run1_cycle", 32'(r), 32'(edge_cycle(s, FRM)));
      push_exp("run1", 3'd4, 1'b1, 1'b1, 1'b0, 3'b000);
      check_out();

      // Mute request held for 5 cycles
      low_mask = '0; rdy_mask = '0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         mute = (i < 5);
         @(negedge clk);
         low_mask[i] = !nmute;
         rdy_mask[i] = ready;
      end
      chk("mute_window", 32'(low_mask), 32'(10'b0000111110));
      chk("mute_ready", 32'(rdy_mask), 32'(10'h3FF));

      // Rate change to 96k from RUN
      pulse_req(2'b11);
      @(negedge clk);
      push_exp("rate_req", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      check_out();
      @(negedge clk);
      push_exp("rate_pins", 3'd1, 1'b0, 1'b0, 1'b0, 3'b001);
      check_out();
      wait_state(3'd2, 300, "sync2", s);
      wait_state(3'd4, 6000, "run2", r);
      chk("run2_cycle", 32'(r), 32'(edge_cycle(s, FRM)));
      push_exp("run2", 3'd4, 1'b1, 1'b1, 1'b0, 3'b001);
      check_out();
      pulse_req(2'b11);
      @(negedge clk);
      push_exp("same_rate", 3'd4, 1'b1, 1'b1, 1'b0, 3'b001);
      check_out();
      @(negedge clk);
      push_exp("same_rate2", 3'd4, 1'b1, 1'b1, 1'b0, 3'b001);
      check_out();

      // LRCK loss in RUN
      lrck_en = 1'b0;
      wait_state(3'd5, 5000, "loss_fault", f);
      chk("loss_cycle", 32'(f), 32'(rises[$] + 3 + TMO));
      push_exp("loss", 3'd5, 1'b0, 1'b0, 1'b1, 3'b001);
      check_out();

      // Reset with LRCK held low, then timeout in ADC_SYNC
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      push_exp("rst_from_fault", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      check_out();
      wait_state(3'd2, 300, "sync3", s);
      nm_seen = 1'b0;
      wait_state(3'd5, 2500, "sync_fault", f);
      chk("sync_timeout_len", 32'(f - s), 32'(TMO));
      chk("nmute_before_fault", 32'(nm_seen), 32'd0);
      push_exp("sync_fault", 3'd5, 1'b0, 1'b0, 1'b1, 3'b000);
      check_out();
      pulse_req(2'b00);
      @(negedge clk);
      push_exp("fault_exit", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      check_out();
      @(negedge clk);
      chk("fault_exit_pll", 32'(state), 32'd1);

      // Restart in PLL_WAIT, then reset midway through ADC_SETTLE
      lrck_en = 1'b1;
      repeat (20) @(negedge clk);
      pulse_req(2'b10);
      @(negedge clk);
      chk("pll_restart_state", 32'(state), 32'd0);
      @(negedge clk);
      push_exp("pll_restart", 3'd1, 1'b0, 1'b0, 1'b0, 3'b100);
      check_out();
      wait_state(3'd2, 300, "sync4", s);
      wait_state(3'd3, 3000, "settle4", e1);
      chk("settle_entry", 32'(e1), 32'(edge_cycle(s, 1)));
      e2 = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         e2 = edge_cycle(s, 2);
         if (e2 >= 0 && cyc >= e2) break;
      end
      chk("second_edge_at", 32'(cyc), 32'(e2));
      chk("settle_after_two", 32'(state), 32'd3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      push_exp("rst_in_settle", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      check_out();
      wait_state(3'd2, 300, "sync5", s);
      wait_state(3'd4, 6000, "run5", r);
      chk("run5_cycle", 32'(r), 32'(edge_cycle(s, FRM)));
      push_exp("run5", 3'd4, 1'b1, 1'b1, 1'b0, 3'b000);
      check_out();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
